// File: rtl/gray_updown_cnt.sv
// WIDTH-bit up/down Gray-code counter with enable, synchronous load, coherent binary output and wrap flag.
// Define GRAY_CNT_SAT_EN for saturating mode: steps past the limits are blocked and wrap becomes a level.
module gray_updown_cnt #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_limit_s;

    assign at_limit_s = up_dn ? (bin_q == MAX_VAL) : (bin_q == MIN_VAL);

    // Next-state selection: load beats count beats hold; Gray is derived from the next binary value.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_val;
            wrap_d = 1'b0;
        end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
            if (at_limit_s) begin
                bin_d  = bin_q;
                wrap_d = 1'b1;
            end else if (up_dn) begin
                bin_d  = bin_q + ONE_VAL;
                wrap_d = 1'b0;
            end else begin
                bin_d  = bin_q - ONE_VAL;
                wrap_d = 1'b0;
            end
`else
            if (up_dn) begin
                bin_d = bin_q + ONE_VAL;
            end else begin
                bin_d = bin_q - ONE_VAL;
            end
            wrap_d = at_limit_s;
`endif
        end else begin
            bin_d  = bin_q;
            wrap_d = 1'b0;
        end
        gray_d = bin2gray(bin_d);
    end

    // Single register stage for both encodings so they can never skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= RESET_VAL;
            gray_q <= bin2gray(RESET_VAL);
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_updown_cnt.sv
// Directed self-checking bench for gray_updown_cnt (WIDTH=4, RESET_VAL=0).
// Wrap-mode scenarios run by default; saturating scenarios run when GRAY_CNT_SAT_EN is defined.
module tb_gray_updown_cnt;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] gray_out;
    logic [3:0] bin_out;
    logic       wrap;

    int errors;
    int checks;

    gray_updown_cnt #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        tick();
        tick();
        checks++; if (bin_out !== 4'd0) begin errors++; $display("FAIL reset_bin: got %0d expected 0", bin_out); end
        checks++; if (gray_out !== 4'd0) begin errors++; $display("FAIL reset_gray: got %0d expected 0", gray_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    endtask

    task automatic test_count_up();
        logic [3:0] gtab [0:16];
        logic [3:0] prev;
        gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
        reset = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        prev = gray_out;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++; if (bin_out !== 4'(i % 16)) begin errors++; $display("FAIL up_bin[%0d]: got %0d expected %0d", i, bin_out, i % 16); end
            checks++; if (gray_out !== gtab[i]) begin errors++; $display("FAIL up_gray[%0d]: got %0d expected %0d", i, gray_out, gtab[i]); end
            checks++; if (wrap !== (i == 16)) begin errors++; $display("FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap, i == 16); end
            checks++; if ($countones(gray_out ^ prev) != 1) begin errors++; $display("FAIL up_onebit[%0d]: got %0d bits changed expected 1", i, $countones(gray_out ^ prev)); end
            prev = gray_out;
        end
    endtask

    task automatic test_count_down();
        logic [3:0] btab [0:2];
        logic [3:0] gtab [0:2];
        btab = '{4'd15, 4'd14, 4'd13};
        gtab = '{4'd8, 4'd9, 4'd11};
        reset = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        reset = 1'b0; en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bin_out !== btab[i]) begin errors++; $display("FAIL dn_bin[%0d]: got %0d expected %0d", i, bin_out, btab[i]); end
            checks++; if (gray_out !== gtab[i]) begin errors++; $display("FAIL dn_gray[%0d]: got %0d expected %0d", i, gray_out, gtab[i]); end
            checks++; if (wrap !== (i == 0)) begin errors++; $display("FAIL dn_wrap[%0d]: got %0b expected %0b", i, wrap, i == 0); end
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 4'd5; en = 1'b1; up_dn = 1'b1;
        tick();
        checks++; if (bin_out !== 4'd5) begin errors++; $display("FAIL load_bin: got %0d expected 5", bin_out); end
        checks++; if (gray_out !== 4'd7) begin errors++; $display("FAIL load_gray: got %0d expected 7", gray_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %0b expected 0", wrap); end
        load = 1'b0;
        tick();
        checks++; if (bin_out !== 4'd6) begin errors++; $display("FAIL load_step_bin: got %0d expected 6", bin_out); end
        checks++; if (gray_out !== 4'd5) begin errors++; $display("FAIL load_step_gray: got %0d expected 5", gray_out); end
    endtask

    task automatic test_hold_reverse();
        logic [3:0] dirs [0:2];
        logic [3:0] btab [0:2];
        logic [3:0] gtab [0:2];
        logic [3:0] prev;
        dirs = '{4'd0, 4'd1, 4'd0};
        btab = '{4'd8, 4'd9, 4'd8};
        gtab = '{4'd12, 4'd13, 4'd12};
        en = 1'b1; up_dn = 1'b1; load = 1'b0;
        tick(); tick(); tick();
        checks++; if (bin_out !== 4'd9 || gray_out !== 4'd13) begin errors++; $display("FAIL hold_start: got %0d/%0d expected 9/13", bin_out, gray_out); end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bin_out !== 4'd9 || gray_out !== 4'd13 || wrap !== 1'b0) begin errors++; $display("FAIL hold[%0d]: got %0d/%0d/%0b expected 9/13/0", i, bin_out, gray_out, wrap); end
        end
        en = 1'b1;
        prev = gray_out;
        for (int i = 0; i < 3; i++) begin
            up_dn = dirs[i][0];
            tick();
            checks++; if (bin_out !== btab[i]) begin errors++; $display("FAIL rev_bin[%0d]: got %0d expected %0d", i, bin_out, btab[i]); end
            checks++; if (gray_out !== gtab[i]) begin errors++; $display("FAIL rev_gray[%0d]: got %0d expected %0d", i, gray_out, gtab[i]); end
            checks++; if ($countones(gray_out ^ prev) != 1) begin errors++; $display("FAIL rev_onebit[%0d]: got %0d bits changed expected 1", i, $countones(gray_out ^ prev)); end
            prev = gray_out;
        end
    endtask

    task automatic test_reset_priority();
        load = 1'b1; load_val = 4'd10; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        checks++; if (bin_out !== 4'd11 || gray_out !== 4'd14) begin errors++; $display("FAIL prio_pre: got %0d/%0d expected 11/14", bin_out, gray_out); end
        reset = 1'b1; load = 1'b1; load_val = 4'd3;
        tick();
        checks++; if (bin_out !== 4'd0 || gray_out !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL prio_reset: got %0d/%0d/%0b expected 0/0/0", bin_out, gray_out, wrap); end
        reset = 1'b0; load = 1'b0;
        tick();
        checks++; if (bin_out !== 4'd1 || gray_out !== 4'd1) begin errors++; $display("FAIL prio_resume: got %0d/%0d expected 1/1", bin_out, gray_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] dirs [0:2];
        logic [3:0] btab [0:2];
        logic [3:0] gtab [0:2];
        logic [3:0] prev;
        dirs = '{4'd0, 4'd0, 4'd1};
        btab = '{4'd0, 4'd15, 4'd0};
        gtab = '{4'd0, 4'd8, 4'd0};
        load = 1'b1; load_val = 4'd1; en = 1'b1;
        tick();
        load = 1'b0;
        prev = gray_out;
        for (int i = 0; i < 3; i++) begin
            up_dn = dirs[i][0];
            tick();
            checks++; if (bin_out !== btab[i] || gray_out !== gtab[i]) begin errors++; $display("FAIL b2b[%0d]: got %0d/%0d expected %0d/%0d", i, bin_out, gray_out, btab[i], gtab[i]); end
            checks++; if (wrap !== (i != 0)) begin errors++; $display("FAIL b2b_wrap[%0d]: got %0b expected %0b", i, wrap, i != 0); end
            checks++; if ($countones(gray_out ^ prev) != 1) begin errors++; $display("FAIL b2b_onebit[%0d]: got %0d bits changed expected 1", i, $countones(gray_out ^ prev)); end
            prev = gray_out;
        end
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 4'd14; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bin_out !== 4'd15 || gray_out !== 4'd8) begin errors++; $display("FAIL sat_up[%0d]: got %0d/%0d expected 15/8", i, bin_out, gray_out); end
            checks++; if (wrap !== (i != 0)) begin errors++; $display("FAIL sat_wrap[%0d]: got %0b expected %0b", i, wrap, i != 0); end
        end
        up_dn = 1'b0;
        tick();
        checks++; if (bin_out !== 4'd14 || gray_out !== 4'd9 || wrap !== 1'b0) begin errors++; $display("FAIL sat_dn: got %0d/%0d/%0b expected 14/9/0", bin_out, gray_out, wrap); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        test_reset();
`ifdef GRAY_CNT_SAT_EN
        reset = 1'b0;
        test_load();
        test_hold_reverse();
        test_reset_priority();
        test_saturate();
`else
        test_count_up();
        test_count_down();
        test_load();
        test_hold_reverse();
        test_reset_priority();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
